bp_be_fe_queue_ckpt: RTL

//  Checkpointed FIFO between the FE and the BE issue stage. Holds FE fetch/exception packets.
//  Has three pointers: write (wptr), speculative read (rptr) and commit checkpoint (cptr).

---
 rtl/bp_be_pkg.sv | 25 ++
 rtl/bp_be_fe_queue_ptr.sv | 34 +++
 rtl/bsg_mem_1r1w.sv | 25 ++
 rtl/bp_be_fe_queue_ckpt.sv | 108 ++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared BE definitions: FE-queue pointer type and helpers.
package bp_be_pkg;

    localparam int unsigned fe_queue_els_gp       = 8;
    localparam int unsigned fe_queue_idx_width_gp = $clog2(fe_queue_els_gp);
    localparam int unsigned fe_queue_ptr_width_gp = fe_queue_idx_width_gp + 1;

    // The wrap bit sits above the index, so a plain +1 toggles it on each wrap.
    typedef struct packed {
        logic                             wrap;
        logic [fe_queue_idx_width_gp-1:0] idx;
    } bp_be_fe_queue_ptr_s;

    function automatic logic bp_be_fe_queue_full(input bp_be_fe_queue_ptr_s cptr,
                                                 input bp_be_fe_queue_ptr_s wptr);
        return (cptr.idx == wptr.idx) && (cptr.wrap != wptr.wrap);
    endfunction

    function automatic bp_be_fe_queue_ptr_s bp_be_fe_queue_ptr_inc(input bp_be_fe_queue_ptr_s p);
        logic [fe_queue_ptr_width_gp-1:0] t;
        t = p;
        return t + fe_queue_ptr_width_gp'(1);
    endfunction

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// FE-queue pointer register; load has priority over increment.
module bp_be_fe_queue_ptr
    import bp_be_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                inc_i,
    input  logic                load_i,
    input  bp_be_fe_queue_ptr_s load_val_i,
    output bp_be_fe_queue_ptr_s ptr_o
);

    bp_be_fe_queue_ptr_s ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = bp_be_fe_queue_ptr_inc(ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_mem_1r1w.sv
// 1-write / 1-async-read register-file storage; contents are not reset.
module bsg_mem_1r1w #(
    parameter int unsigned width_p       = 64,
    parameter int unsigned els_p         = 8,
    parameter int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed FE->BE queue with write, speculative-read and commit pointers.
// Optional same-cycle bypass when empty: define BP_BE_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_ckpt
    import bp_be_pkg::*;
#(
    parameter int unsigned width_p = 64,
    parameter int unsigned els_p   = fe_queue_els_gp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               roll_i,
    input  logic               deq_i,
    input  logic               clr_i
);

    if (els_p != fe_queue_els_gp) begin : g_bad_els
        $error("els_p must match bp_be_pkg::fe_queue_els_gp");
    end

    bp_be_fe_queue_ptr_s wptr, rptr, cptr;
    bp_be_fe_queue_ptr_s cptr_next, rptr_next;
    logic                empty, full, enq, yumi_eff;
    logic [width_p-1:0]  mem_data;

    assign full     = bp_be_fe_queue_full(cptr, wptr);
    assign empty    = (rptr == wptr);
    assign ready_o  = ~full;
    // clr drops a same-cycle enqueue; roll swallows a same-cycle yumi.
    assign enq      = v_i & ~full & ~clr_i;
    assign yumi_eff = yumi_i & ~roll_i;

    assign cptr_next = deq_i ? bp_be_fe_queue_ptr_inc(cptr) : cptr;
    assign rptr_next = roll_i   ? cptr_next
                     : yumi_eff ? bp_be_fe_queue_ptr_inc(rptr)
                     : rptr;

    bp_be_fe_queue_ptr u_wptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (enq),
        .load_i     (clr_i),
        .load_val_i (rptr_next),
        .ptr_o      (wptr)
    );

    bp_be_fe_queue_ptr u_rptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (yumi_eff),
        .load_i     (roll_i),
        .load_val_i (cptr_next),
        .ptr_o      (rptr)
    );

    bp_be_fe_queue_ptr u_cptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (deq_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (cptr)
    );

    bsg_mem_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr.idx),
        .w_data_i (data_i),
        .r_addr_i (rptr.idx),
        .r_data_o (mem_data)
    );

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic bypass_v;
    // A bypassed packet is still written at wptr, so a later roll can replay it.
    assign bypass_v = empty & ~full & v_i & ~roll_i & ~clr_i;

    always_comb begin
        v_o    = ~empty | bypass_v;
        data_o = '0;
        if (!empty) begin
            data_o = mem_data;
        end else if (bypass_v) begin
            data_o = data_i;
        end
    end
`else
    always_comb begin
        v_o    = ~empty;
        data_o = empty ? '0 : mem_data;
    end
`endif

    a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o);
    a_deq_needs_read : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq_i |-> (cptr != rptr));

endmodule
